impl_checker: RTL and testbench
===============================

Name: impl_checker

Overview:
- Synthesizable RTL monitor that evaluates implication-style properties between two 1-bit signals: overlapped (`ante |-> cons`), non-overlapped (`ante |=> cons`) and fixed-delay (`ante` followed by `cons` exactly D cycles later).
- It sits directly downstream of the assignment/operator stage. It consumes that stage's registered comparison results as `ante` and `cons`.
- It produces pass/fail counts and a sticky failure flag for the status register block.

Parameters:
- MAX_DLY, 4: maximum delay, in cycles, for fixed-delay mode; legal range 1..8.
- CNT_W, 16: width of the pass counter, fail counter and timestamp counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of all counters, flags and pending obligations.
- en  input  1  enables creation of new obligations.
- mode  input  2  0 = overlapped, 1 = non-overlapped, 2 = fixed delay, 3 = reserved (behaves as 1).
- dly  input  $clog2(MAX_DLY+1)  delay for mode 2.
- ante  input  1  antecedent.
- cons  input  1  consequent.
- pass_cnt  output  CNT_W  number of satisfied obligations.
- fail_cnt  output  CNT_W  number of violated obligations.
- fail_pulse  output  1  high for one cycle after any violation is evaluated.
- fail_sticky  output  1  set on the first violation; cleared only by clr or reset.
- first_fail_time  output  CNT_W  timestamp of the first violation.
- pending  output  1  at least one obligation is outstanding.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0, the obligation shift register is 0 and the timestamp counter is 0.
- Timestamp counter:
  - Free-running; increments every cycle and wraps modulo 2^CNT_W.
  - clr resets it to 0.
- Effective delay E, latched at obligation creation:
  - mode 0 → E = 0.
  - mode 1 or 3 → E = 1.
  - mode 2 → E = dly, clamped to MAX_DLY.
  - mode 2 with dly = 0 → E = 0.
- Obligation creation: occurs in any cycle where en = 1 and ante = 1.
  - E = 0: the obligation is evaluated against cons in the same cycle.
  - E > 0: a 1 is inserted at slot E-1 of a MAX_DLY-bit shift register.
- Shift register:
  - Shifts toward slot 0 every cycle.
  - The bit leaving slot 0 marks an obligation due in the current cycle.
- Evaluation:
  - Obligations due this cycle are the shifted-out bit plus any E = 0 obligation; there are at most two.
  - Each due obligation passes if cons = 1 and fails otherwise.
  - Two due obligations in the same cycle are both counted, so a counter can increment by 2.
- Counters:
  - Both update on the clock edge that ends the evaluating cycle (latency 1).
  - Both saturate at 2^CNT_W − 1 and never wrap.
- fail_pulse: registered; high in the cycle after an evaluating cycle that had one or more failures.
- fail_sticky and first_fail_time:
  - On the first failure, fail_sticky is set.
  - first_fail_time captures the timestamp value of the evaluating cycle.
  - Later failures do not update first_fail_time.
- mode or dly changes: apply only to newly created obligations. Outstanding obligations keep their original due cycle.
- en = 0: blocks creation only. Outstanding obligations are still evaluated.
- pending: registered; equals the OR of the shift register after the edge.
- clr priority:
  - clr overrides evaluation and creation in the same cycle; everything clears and nothing is counted.
  - The timestamp is 0 on the following cycle.
- Reset mid-operation: discards all outstanding obligations with no pass/fail accounting.
- Back-to-back antecedents: ante held high for N cycles in mode 1 creates N independent obligations, evaluated on consecutive cycles.

Test Plan:
1. Mode 0; ante = 1, cons = 1 for 3 cycles, then one cycle of ante = 1, cons = 0 → pass_cnt = 3, fail_cnt = 1. fail_pulse is high for exactly 1 cycle. fail_sticky = 1. first_fail_time = 3.
2. Mode 1; single ante pulse at t = 5, cons = 1 only at t = 6 → pass_cnt = 1, fail_cnt = 0. pending is high for 1 cycle (after the t = 5 edge).
3. Mode 2, dly = 3; ante pulses at t = 10 and t = 11, cons = 1 at t = 13 only → one pass and one fail (the fail is due at t = 14). first_fail_time = 14.
4. Mode 2, dly = 2; ante at t = 4; mode switches to 0 at t = 6 with ante = 1 and cons = 0 → two failures in one cycle, fail_cnt = 2. Also, with mode 2 and dly = 7 (> MAX_DLY = 4), an obligation is evaluated 4 cycles later.
5. CNT_W = 4; 20 passing obligations → pass_cnt saturates at 15.
6. Obligations pending, then clr = 1 for one cycle → all counters, flags and pending are 0 and no late evaluations occur. Repeat with rst_n dropped mid-window → same result asynchronously.

Source files
------------

// File: rtl/impl_checker.sv
// Implication-property monitor: checks ante |-> cons, ante |=> cons and
// ante ##D cons, counting passes/failures and latching the first failure time.
module impl_checker #(
  parameter int MAX_DLY = 4,
  parameter int CNT_W   = 16,
  localparam int DLY_W  = $clog2(MAX_DLY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DLY_W-1:0] dly,
  input  logic             ante,
  input  logic             cons,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_pulse,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] first_fail_time,
  output logic             pending
);

  logic [CNT_W-1:0]   ts;
  logic [MAX_DLY-1:0] oblig;
  logic [MAX_DLY-1:0] oblig_next;
  logic [DLY_W-1:0]   e_dly;
  logic               create;
  logic               due_now;
  logic               due_shift;
  logic [1:0]         n_pass;
  logic [1:0]         n_fail;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    case (mode)
      2'd0:    e_dly = '0;
      2'd2:    e_dly = (dly > DLY_W'(MAX_DLY)) ? DLY_W'(MAX_DLY) : dly;
      default: e_dly = DLY_W'(1);
    endcase
  end

  // Up to two obligations can fall due together: the one leaving slot 0 and
  // a zero-delay one created this cycle.
  always_comb begin
    create    = en & ante;
    due_now   = create & (e_dly == '0);
    due_shift = oblig[0];
    n_pass    = {1'b0, due_shift & cons}  + {1'b0, due_now & cons};
    n_fail    = {1'b0, due_shift & ~cons} + {1'b0, due_now & ~cons};
    oblig_next = oblig >> 1;
    for (int i = 0; i < MAX_DLY; i++) begin
      if (create && e_dly == DLY_W'(i + 1)) oblig_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts              <= '0;
      oblig           <= '0;
      pending         <= 1'b0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      fail_pulse      <= 1'b0;
      fail_sticky     <= 1'b0;
      first_fail_time <= '0;
    end else if (clr) begin
      ts              <= '0;
      oblig           <= '0;
      pending         <= 1'b0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      fail_pulse      <= 1'b0;
      fail_sticky     <= 1'b0;
      first_fail_time <= '0;
    end else begin
      ts         <= ts + CNT_W'(1);
      oblig      <= oblig_next;
      pending    <= |oblig_next;
      pass_cnt   <= sat_add(pass_cnt, n_pass);
      fail_cnt   <= sat_add(fail_cnt, n_fail);
      fail_pulse <= (n_fail != 2'd0);
      if (n_fail != 2'd0 && !fail_sticky) begin
        fail_sticky     <= 1'b1;
        first_fail_time <= ts;
      end
    end
  end

endmodule

// File: tb/tb_impl_checker.sv
// Bench for impl_checker: directed vector table, hand-written corner
// sequences, and randomized traffic against a due-time reference model.
module tb_impl_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, en, ante, cons;
  logic [1:0]  mode;
  logic [2:0]  dly;
  logic [15:0] pass_cnt, fail_cnt, first_fail_time;
  logic        fail_pulse, fail_sticky, pending;
  logic [3:0]  s_pass, s_fail, s_fft;
  logic        s_pulse, s_sticky, s_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  impl_checker #(.MAX_DLY(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .dly(dly),
    .ante(ante), .cons(cons), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_pulse(fail_pulse), .fail_sticky(fail_sticky),
    .first_fail_time(first_fail_time), .pending(pending));

  impl_checker #(.MAX_DLY(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .dly(dly),
    .ante(ante), .cons(cons), .pass_cnt(s_pass), .fail_cnt(s_fail),
    .fail_pulse(s_pulse), .fail_sticky(s_sticky),
    .first_fail_time(s_fft), .pending(s_pend));

  // Reference model: obligations are recorded by the absolute cycle they fall due.
  bit due_at [64];
  int m_t, m_ts, m_pass, m_fail, m_pass4, m_fail4, m_fft, m_fft4;
  bit m_pulse, m_sticky, m_pend;

  task automatic model_reset();
    foreach (due_at[i]) due_at[i] = 1'b0;
    m_ts = 0; m_pass = 0; m_fail = 0; m_pass4 = 0; m_fail4 = 0;
    m_fft = 0; m_fft4 = 0; m_pulse = 0; m_sticky = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit c, input bit e, input int md, input int d,
                            input bit a, input bit co);
    int eff, np, nf;
    bit due, now;
    if (c) begin
      model_reset();
      m_t++;
      return;
    end
    eff = (md == 0) ? 0 : (md == 2) ? ((d > 4) ? 4 : d) : 1;
    due = due_at[m_t % 64];
    due_at[m_t % 64] = 1'b0;
    now = e && a && (eff == 0);
    if (e && a && eff > 0) due_at[(m_t + eff) % 64] = 1'b1;
    np = int'(due && co) + int'(now && co);
    nf = int'(due && !co) + int'(now && !co);
    m_pass  = (m_pass + np > 65535) ? 65535 : m_pass + np;
    m_fail  = (m_fail + nf > 65535) ? 65535 : m_fail + nf;
    m_pass4 = (m_pass4 + np > 15) ? 15 : m_pass4 + np;
    m_fail4 = (m_fail4 + nf > 15) ? 15 : m_fail4 + nf;
    m_pulse = (nf > 0);
    if (nf > 0 && !m_sticky) begin
      m_sticky = 1'b1;
      m_fft  = m_ts;
      m_fft4 = m_ts % 16;
    end
    m_ts = (m_ts + 1) % 65536;
    m_pend = 1'b0;
    foreach (due_at[i]) if (due_at[i]) m_pend = 1'b1;
    m_t++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit c, input bit e, input int md, input int d,
                      input bit a, input bit co);
    clr = c; en = e; mode = 2'(md); dly = 3'(d); ante = a; cons = co;
    model_step(c, e, md, d, a, co);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pass"},    int'(pass_cnt),        m_pass);
    chk({tag, ".fail"},    int'(fail_cnt),        m_fail);
    chk({tag, ".pulse"},   int'(fail_pulse),      int'(m_pulse));
    chk({tag, ".sticky"},  int'(fail_sticky),     int'(m_sticky));
    chk({tag, ".fft"},     int'(first_fail_time), m_fft);
    chk({tag, ".pending"}, int'(pending),         int'(m_pend));
    chk({tag, ".s_pass"},  int'(s_pass),          m_pass4);
    chk({tag, ".s_fail"},  int'(s_fail),          m_fail4);
    chk({tag, ".s_fft"},   int'(s_fft),           m_fft4);
  endtask

  typedef struct {
    bit c, e; int md, d; bit a, co;
    int pass, fail; bit pulse, sticky; int fft; bit pend;
  } vec_t;

  function automatic vec_t mk(bit c, bit e, int md, int d, bit a, bit co,
                              int p, int f, bit pu, bit st, int ft, bit pe);
    vec_t v;
    v.c = c; v.e = e; v.md = md; v.d = d; v.a = a; v.co = co;
    v.pass = p; v.fail = f; v.pulse = pu; v.sticky = st; v.fft = ft; v.pend = pe;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    tbl[0]  = mk(0,1,0,0,1,1, 1,0,0,0,0,0);
    tbl[1]  = mk(0,1,0,0,1,1, 2,0,0,0,0,0);
    tbl[2]  = mk(0,1,0,0,1,1, 3,0,0,0,0,0);
    tbl[3]  = mk(0,1,0,0,1,0, 3,1,1,1,3,0);
    tbl[4]  = mk(0,1,0,0,0,0, 3,1,0,1,3,0);
    tbl[5]  = mk(1,1,0,0,1,0, 0,0,0,0,0,0);
    tbl[6]  = mk(0,1,1,0,1,0, 0,0,0,0,0,1);
    tbl[7]  = mk(0,1,1,0,0,1, 1,0,0,0,0,0);
    tbl[8]  = mk(0,1,1,0,0,0, 1,0,0,0,0,0);
    tbl[9]  = mk(1,0,0,0,0,0, 0,0,0,0,0,0);
    tbl[10] = mk(0,1,3,0,1,0, 0,0,0,0,0,1);
    tbl[11] = mk(0,1,3,0,0,0, 0,1,1,1,1,0);
    tbl[12] = mk(0,1,1,0,0,0, 0,1,0,1,1,0);
    tbl[13] = mk(0,0,1,0,1,0, 0,1,0,1,1,0);
    tbl[14] = mk(0,0,1,0,0,0, 0,1,0,1,1,0);
    tbl[15] = mk(0,1,1,0,1,0, 0,1,0,1,1,1);
    tbl[16] = mk(0,0,1,0,0,1, 1,1,0,1,1,0);
    tbl[17] = mk(0,1,2,0,1,0, 1,2,1,1,1,0);

    rst_n = 1'b0; clr = 0; en = 0; mode = 0; dly = 0; ante = 0; cons = 0;
    model_reset();
    m_t = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pass", int'(pass_cnt), 0);
    chk("reset.fail", int'(fail_cnt), 0);
    chk("reset.sticky", int'(fail_sticky), 0);
    chk("reset.pending", int'(pending), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      string n;
      step(tbl[i].c, tbl[i].e, tbl[i].md, tbl[i].d, tbl[i].a, tbl[i].co);
      n = $sformatf("vec%0d", i);
      chk({n, ".pass"},    int'(pass_cnt),        tbl[i].pass);
      chk({n, ".fail"},    int'(fail_cnt),        tbl[i].fail);
      chk({n, ".pulse"},   int'(fail_pulse),      int'(tbl[i].pulse));
      chk({n, ".sticky"},  int'(fail_sticky),     int'(tbl[i].sticky));
      chk({n, ".fft"},     int'(first_fail_time), tbl[i].fft);
      chk({n, ".pending"}, int'(pending),         int'(tbl[i].pend));
    end

    // Fixed delay 3: antes at ts 10 and 11, cons only at ts 13
    step(1, 0, 0, 0, 0, 0);
    idle(10);
    step(0, 1, 2, 3, 1, 0);
    step(0, 1, 2, 3, 1, 0);
    step(0, 1, 2, 3, 0, 0);
    step(0, 1, 2, 3, 0, 1);
    chk("dly3.pass_at13", int'(pass_cnt), 1);
    chk("dly3.fail_at13", int'(fail_cnt), 0);
    step(0, 1, 2, 3, 0, 0);
    chk("dly3.fail", int'(fail_cnt), 1);
    chk("dly3.fft", int'(first_fail_time), 14);
    chk("dly3.pending", int'(pending), 0);

    // Delayed and zero-delay obligations colliding in one cycle
    step(1, 0, 0, 0, 0, 0);
    idle(4);
    step(0, 1, 2, 2, 1, 1);
    step(0, 1, 2, 2, 0, 1);
    step(0, 1, 0, 0, 1, 0);
    chk("collide.fail", int'(fail_cnt), 2);
    chk("collide.pulse", int'(fail_pulse), 1);
    chk("collide.fft", int'(first_fail_time), 6);

    // dly beyond MAX_DLY clamps to 4
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2, 7, 1, 0);
    step(0, 1, 2, 7, 0, 1);
    step(0, 1, 2, 7, 0, 1);
    step(0, 1, 2, 7, 0, 1);
    chk("clamp.early_pass", int'(pass_cnt), 0);
    chk("clamp.pending", int'(pending), 1);
    step(0, 1, 2, 7, 0, 1);
    chk("clamp.pass", int'(pass_cnt), 1);
    chk("clamp.pending_done", int'(pending), 0);

    // Saturation of the narrow instance
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 1, 1);
    chk("sat.s_pass", int'(s_pass), 15);
    chk("sat.pass", int'(pass_cnt), 20);

    // clr with obligations outstanding
    step(0, 1, 2, 4, 1, 0);
    step(0, 1, 2, 4, 1, 0);
    chk("clr.pending_before", int'(pending), 1);
    step(1, 1, 2, 4, 0, 0);
    chk("clr.pass", int'(pass_cnt), 0);
    chk("clr.fail", int'(fail_cnt), 0);
    chk("clr.pending", int'(pending), 0);
    idle(6);
    chk("clr.no_late_fail", int'(fail_cnt), 0);
    chk("clr.no_late_pulse", int'(fail_sticky), 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    chk("clr.ts_zero", int'(first_fail_time), 0);
    chk("clr.sticky", int'(fail_sticky), 1);

    // Asynchronous reset with obligations outstanding
    step(0, 1, 2, 3, 1, 0);
    step(0, 1, 2, 3, 1, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("arst.fail", int'(fail_cnt), 0);
    chk("arst.sticky", int'(fail_sticky), 0);
    chk("arst.pending", int'(pending), 0);
    #1;
    rst_n = 1'b1;
    idle(6);
    chk("arst.no_late_fail", int'(fail_cnt), 0);
    chk("arst.no_late_pass", int'(pass_cnt), 0);
    check_model("arst");

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
